// File: rtl/usbsd_sel_debounce.sv
// USB/SD select switch conditioner: synchronises and debounces the raw pin, then
// drives the USB and SD bus-switch enables with a break-before-make gap.
module usbsd_sel_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int DB_CNT_W        = 16,
   parameter int GAP_CYCLES      = 16,
   parameter int GAP_CNT_W       = 5
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sel_raw,
   output logic sel_level,
   output logic sel_change,
   output logic usb_en,
   output logic sd_en,
   output logic switching
);

   // state   | meaning
   // ST_GAP  | both enables low, gap timer running down
   // ST_USB  | USB bus switch connected (sel_level 0)
   // ST_SD   | SD bus switch connected (sel_level 1)
   typedef enum logic [1:0] {ST_GAP, ST_USB, ST_SD} state_t;

   localparam logic [DB_CNT_W-1:0]  DB_LOAD  = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   sync_q;
   logic [DB_CNT_W-1:0]    db_cnt;
   logic [GAP_CNT_W-1:0]   gap_cnt;
   state_t                 state;

   assign sync_q = sync_ff[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], sel_raw};
      end
   end

   // db_cnt holds the mismatch clocks still required; hitting zero accepts the level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt     <= DB_LOAD;
         sel_level  <= 1'b0;
         sel_change <= 1'b0;
      end else begin
         sel_change <= 1'b0;
         if (sync_q == sel_level) begin
            db_cnt <= DB_LOAD;
         end else if (db_cnt == '0) begin
            sel_level  <= sync_q;
            sel_change <= 1'b1;
            db_cnt     <= DB_LOAD;
         end else begin
            db_cnt <= db_cnt - 1'b1;
         end
      end
   end

   // sel_level is only looked at in GAP on the exit edge, so toggles mid-gap are ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_GAP;
         gap_cnt   <= GAP_LOAD;
         usb_en    <= 1'b0;
         sd_en     <= 1'b0;
         switching <= 1'b1;
      end else begin
         case (state)
            ST_USB: begin
               if (sel_level) begin
                  state     <= ST_GAP;
                  gap_cnt   <= GAP_LOAD;
                  usb_en    <= 1'b0;
                  switching <= 1'b1;
               end
            end
            ST_SD: begin
               if (!sel_level) begin
                  state     <= ST_GAP;
                  gap_cnt   <= GAP_LOAD;
                  sd_en     <= 1'b0;
                  switching <= 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  switching <= 1'b0;
                  if (sel_level) begin
                     state <= ST_SD;
                     sd_en <= 1'b1;
                  end else begin
                     state  <= ST_USB;
                     usb_en <= 1'b1;
                  end
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               state     <= ST_GAP;
               gap_cnt   <= GAP_LOAD;
               usb_en    <= 1'b0;
               sd_en     <= 1'b0;
               switching <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usbsd_sel_debounce.sv
// Bench for usbsd_sel_debounce: directed scenarios with hand-derived timing plus a
// random run against an event-level reference model.
module tb_usbsd_sel_debounce;

   localparam int DB  = 8;
   localparam int GAP = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic sel_raw = 1'b0;
   logic sel_raw2 = 1'b0;
   logic sel_level, sel_change, usb_en, sd_en, switching;
   logic sel_level2, sel_change2, usb_en2, sd_en2, switching2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   usbsd_sel_debounce #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DB), .DB_CNT_W(16), .GAP_CYCLES(GAP), .GAP_CNT_W(5)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sel_raw(sel_raw), .sel_level(sel_level),
      .sel_change(sel_change), .usb_en(usb_en), .sd_en(sd_en), .switching(switching)
   );

   // Short debounce, long gap: lets sel_level really change while a gap is running.
   usbsd_sel_debounce #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(2), .DB_CNT_W(4), .GAP_CYCLES(12), .GAP_CNT_W(4)
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .sel_raw(sel_raw2), .sel_level(sel_level2),
      .sel_change(sel_change2), .usb_en(usb_en2), .sd_en(sd_en2), .switching(switching2)
   );

   // Reference model: raw history, mismatch run length, and gap-exit timestamps.
   logic h1, h2, m_level, m_change, m_in_gap, m_conn;
   int   m_run, m_edge, m_gap_exit;
   logic n_level, n_change, n_in_gap, n_conn;
   int   n_run, n_exit;

   always_comb begin
      n_run    = (h2 != m_level) ? m_run + 1 : 0;
      n_level  = m_level;
      n_change = 1'b0;
      if (n_run == DB) begin
         n_level  = ~m_level;
         n_change = 1'b1;
         n_run    = 0;
      end
      n_in_gap = m_in_gap;
      n_conn   = m_conn;
      n_exit   = m_gap_exit;
      if (m_in_gap) begin
         if (m_edge + 1 == m_gap_exit) begin
            n_in_gap = 1'b0;
            n_conn   = m_level;
         end
      end else if (m_level != m_conn) begin
         n_in_gap = 1'b1;
         n_exit   = m_edge + 1 + GAP;
      end
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h1 <= 1'b0; h2 <= 1'b0; m_level <= 1'b0; m_change <= 1'b0;
         m_in_gap <= 1'b1; m_conn <= 1'b0; m_run <= 0; m_edge <= 0; m_gap_exit <= GAP;
      end else begin
         h2 <= h1; h1 <= sel_raw;
         m_run <= n_run; m_level <= n_level; m_change <= n_change;
         m_in_gap <= n_in_gap; m_conn <= n_conn; m_gap_exit <= n_exit;
         m_edge <= m_edge + 1;
      end
   end

   task automatic test_reset;
      reset_n = 1'b0; sel_raw = 1'b0; sel_raw2 = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({sel_level, sel_change, usb_en, sd_en, switching} !== 5'b00001) begin
         n_fail++;
         $display("FAIL reset_values: got lvl/chg/usb/sd/sw=%b want 00001",
                  {sel_level, sel_change, usb_en, sd_en, switching});
      end
      reset_n = 1'b1;
      for (int k = 1; k <= GAP; k++) begin
         @(negedge clk);
         n_tests++;
         if (k < GAP) begin
            if ({usb_en, sd_en, switching} !== 3'b001) begin
               n_fail++;
               $display("FAIL reset_gap k=%0d: got usb/sd/sw=%b want 001", k, {usb_en, sd_en, switching});
            end
         end else if ({sel_level, usb_en, sd_en, switching} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_exit: got lvl/usb/sd/sw=%b want 0100",
                     {sel_level, usb_en, sd_en, switching});
         end
      end
   endtask

   task automatic test_glitch;
      sel_raw = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         n_tests++;
         if ({sel_level, sel_change, usb_en, sd_en} !== 4'b0010) begin
            n_fail++;
            $display("FAIL glitch k=%0d: got lvl/chg/usb/sd=%b want 0010",
                     k, {sel_level, sel_change, usb_en, sd_en});
         end
         if (k == 5) sel_raw = 1'b0;
      end
   endtask

   task automatic test_switch;
      logic [4:0] exp;
      sel_raw = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp = {(k >= 10) ? 1'b1 : 1'b0, (k == 10) ? 1'b1 : 1'b0, (k <= 10) ? 1'b1 : 1'b0,
                (k >= 15) ? 1'b1 : 1'b0, (k >= 11 && k <= 14) ? 1'b1 : 1'b0};
         n_tests++;
         if ({sel_level, sel_change, usb_en, sd_en, switching} !== exp) begin
            n_fail++;
            $display("FAIL switch k=%0d: got lvl/chg/usb/sd/sw=%b want %b",
                     k, {sel_level, sel_change, usb_en, sd_en, switching}, exp);
         end
      end
   endtask

   task automatic test_bounce;
      logic [4:0] pat;
      int pulses, pos;
      pat = 5'b01101;  // bit i is the raw value for bounce clock i: 1,0,1,1,0
      sel_raw = 1'b0;
      repeat (30) @(negedge clk);
      n_tests++;
      if ({sel_level, usb_en, sd_en} !== 3'b010) begin
         n_fail++;
         $display("FAIL bounce_pre: got lvl/usb/sd=%b want 010", {sel_level, usb_en, sd_en});
      end
      pulses = 0; pos = -1;
      sel_raw = pat[0];
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (sel_change === 1'b1) begin
            pulses++;
            pos = k;
         end
         if (k == 20) begin
            n_tests++;
            if ({usb_en, sd_en, switching} !== 3'b010) begin
               n_fail++;
               $display("FAIL bounce_sd_on: got usb/sd/sw=%b want 010", {usb_en, sd_en, switching});
            end
         end
         sel_raw = (k < 5) ? pat[k] : 1'b1;
      end
      n_tests++;
      if (pulses != 1 || pos != 15) begin
         n_fail++;
         $display("FAIL bounce_change: got %0d pulses at clk %0d want 1 at clk 15", pulses, pos);
      end
   endtask

   task automatic test_gap_toggle;
      logic [3:0] exp;
      logic lvl;
      sel_raw2 = 1'b1;
      repeat (40) @(negedge clk);
      n_tests++;
      if ({sel_level2, usb_en2, sd_en2, switching2} !== 4'b1010) begin
         n_fail++;
         $display("FAIL gap_toggle_pre: got lvl/usb/sd/sw=%b want 1010",
                  {sel_level2, usb_en2, sd_en2, switching2});
      end
      sel_raw2 = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         lvl = (k < 4 || k >= 8) ? 1'b1 : 1'b0;
         if (k <= 4)       exp = {lvl, 3'b010};
         else if (k <= 16) exp = {lvl, 3'b001};
         else              exp = {lvl, 3'b010};
         n_tests++;
         if ({sel_level2, usb_en2, sd_en2, switching2} !== exp) begin
            n_fail++;
            $display("FAIL gap_toggle k=%0d: got lvl/usb/sd/sw=%b want %b",
                     k, {sel_level2, usb_en2, sd_en2, switching2}, exp);
         end
         if (k == 4) sel_raw2 = 1'b1;
      end
   endtask

   task automatic test_random;
      int hold;
      logic [4:0] exp;
      hold = 0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         exp = {m_level, m_change, ~m_in_gap & ~m_conn, ~m_in_gap & m_conn, m_in_gap};
         n_tests++;
         if ({sel_level, sel_change, usb_en, sd_en, switching} !== exp) begin
            n_fail++;
            $display("FAIL random c=%0d: got lvl/chg/usb/sd/sw=%b want %b",
                     c, {sel_level, sel_change, usb_en, sd_en, switching}, exp);
         end
         n_tests++;
         if ((usb_en & sd_en) !== 1'b0) begin
            n_fail++;
            $display("FAIL random_exclusive c=%0d: got usb&sd=%b want 0", c, usb_en & sd_en);
         end
         if (hold == 0) begin
            sel_raw = ~sel_raw;
            hold = $urandom_range(14, 1);
         end else begin
            hold--;
         end
      end
   endtask

   task automatic test_mid_gap_reset;
      int waited;
      sel_raw = 1'b0;
      repeat (30) @(negedge clk);
      sel_raw = 1'b1;
      waited = 0;
      @(negedge clk);
      while (switching !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      n_tests++;
      if (switching !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_gap_wait: got switching=%b want 1 within 40 clks", switching);
      end
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_tests++;
      if ({sel_level, sel_change, usb_en, sd_en, switching} !== 5'b00001) begin
         n_fail++;
         $display("FAIL mid_gap_async_reset: got lvl/chg/usb/sd/sw=%b want 00001",
                  {sel_level, sel_change, usb_en, sd_en, switching});
      end
      @(negedge clk);
      test_reset();
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_switch();
      test_bounce();
      test_gap_toggle();
      test_random();
      test_mid_gap_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
